// File: rtl/pipe_ctl_pkg.sv
// Shared types and constants for the integer-unit pipe sequencing controller.
package pipe_ctl_pkg;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StTrapEnter,
        StTrapBuild
    } pipe_state_e;

    localparam logic [3:0] SEL_PIPE   = 4'b0001;
    localparam logic [3:0] SEL_DATA   = 4'b0010;
    localparam logic [3:0] SEL_SHADOW = 4'b0100;
    localparam logic [3:0] SEL_INIT   = 4'b1000;

    localparam logic [31:0] OPTOP_INIT = 32'h003ffffc;

endpackage

// File: rtl/pipe_valid_stage.sv
// Occupancy flop for one pipe stage; set beats kill, kill beats advance.
module pipe_valid_stage (
    input  logic clk,
    input  logic reset_l,
    input  logic adv_i,
    input  logic d_i,
    input  logic kill_i,
    input  logic set_i,
    output logic valid_o
);

    logic valid_d, valid_q;

    always_comb begin
        valid_d = valid_q;
        if (set_i) begin
            valid_d = 1'b1;
        end else if (kill_i) begin
            valid_d = 1'b0;
        end else if (adv_i) begin
            valid_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_ctl.sv
// Sequencing controller for the PC/OPTOP pipe: stage occupancy, stalls, flushes, trap entry.
module pipe_ctl
    import pipe_ctl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_l,
    input  logic       dispatch_d,
    input  logic       hold_r,
    input  logic       hold_e,
    input  logic       hold_c,
    input  logic       kill_e,
    input  logic       trap_req_c,
    input  logic       trap_done,
    input  logic       optop_wr_e,
    input  logic       optop_wr_c,
    input  logic       optop_restore,
    output logic [2:0] pc_enable,
    output logic [2:0] optop_enable,
    output logic [3:0] optop_sel_e,
    output logic [3:0] optop_sel_c,
    output logic       trap_in_progress,
    output logic       valid_r,
    output logic       valid_e,
    output logic       valid_c
);

    pipe_state_e state_d, state_q;

    logic adv_r, adv_e, adv_c;
    logic r_adv, r_kill, r_set;
    logic e_adv, e_kill, e_set;
    logic c_adv, c_kill, c_set;

    always_comb begin
        adv_c = ~hold_c;
        adv_e = adv_c & ~hold_e;
        adv_r = adv_e & ~hold_r;

        state_d          = state_q;
        pc_enable        = 3'b000;
        optop_enable     = {1'b0, optop_wr_c | optop_restore, optop_wr_e | optop_restore};
        trap_in_progress = 1'b0;
        r_adv  = 1'b0;
        r_kill = 1'b0;
        r_set  = 1'b0;
        e_adv  = 1'b0;
        e_kill = 1'b0;
        e_set  = 1'b0;
        c_adv  = 1'b0;
        c_kill = 1'b0;
        c_set  = 1'b0;

        unique case (state_q)
            StInit: begin
                optop_enable = 3'b011;
                state_d      = StRun;
            end
            StRun: begin
                // A trapping C instruction overrides any kill arriving the same cycle.
                pc_enable[0]    = adv_r & dispatch_d;
                pc_enable[1]    = adv_e & (~kill_e | trap_req_c);
                pc_enable[2]    = adv_c & valid_e;
                optop_enable[0] = adv_e | optop_wr_e | optop_restore;
                optop_enable[1] = (adv_c & valid_e) | optop_wr_c | optop_restore;
                if (trap_req_c) begin
                    r_kill  = 1'b1;
                    e_kill  = 1'b1;
                    state_d = StTrapEnter;
                end else begin
                    r_adv  = adv_r;
                    e_adv  = adv_e;
                    c_adv  = adv_c;
                    r_kill = kill_e;
                    e_kill = kill_e;
                end
            end
            StTrapEnter: begin
                // The trapping instruction re-enters E to run the trap-frame ucode.
                trap_in_progress = 1'b1;
                pc_enable        = 3'b010;
                optop_enable[2]  = 1'b1;
                r_kill           = 1'b1;
                e_set            = 1'b1;
                c_kill           = 1'b1;
                state_d          = StTrapBuild;
            end
            StTrapBuild: begin
                trap_in_progress = 1'b1;
                if (trap_done) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase

        if (state_q == StInit) begin
            optop_sel_e = SEL_INIT;
            optop_sel_c = SEL_INIT;
        end else begin
            optop_sel_e = optop_restore ? SEL_SHADOW : (optop_wr_e ? SEL_DATA : SEL_PIPE);
            optop_sel_c = optop_restore ? SEL_SHADOW : (optop_wr_c ? SEL_DATA : SEL_PIPE);
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_valid_stage u_valid_r (
        .clk     (clk),
        .reset_l (reset_l),
        .adv_i   (r_adv),
        .d_i     (dispatch_d),
        .kill_i  (r_kill),
        .set_i   (r_set),
        .valid_o (valid_r)
    );

    pipe_valid_stage u_valid_e (
        .clk     (clk),
        .reset_l (reset_l),
        .adv_i   (e_adv),
        .d_i     (valid_r),
        .kill_i  (e_kill),
        .set_i   (e_set),
        .valid_o (valid_e)
    );

    pipe_valid_stage u_valid_c (
        .clk     (clk),
        .reset_l (reset_l),
        .adv_i   (c_adv),
        .d_i     (valid_e),
        .kill_i  (c_kill),
        .set_i   (c_set),
        .valid_o (valid_c)
    );

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl: reset/INIT, pipe fill, stalls, trap entry/exit, OPTOP select priority.
module tb_pipe_ctl;

    logic       clk = 1'b0;
    logic       reset_l;
    logic       dispatch_d, hold_r, hold_e, hold_c, kill_e;
    logic       trap_req_c, trap_done, optop_wr_e, optop_wr_c, optop_restore;
    logic [2:0] pc_enable, optop_enable;
    logic [3:0] optop_sel_e, optop_sel_c;
    logic       trap_in_progress, valid_r, valid_e, valid_c;

    int n_checks = 0;
    int n_errors = 0;

    pipe_ctl dut (
        .clk              (clk),
        .reset_l          (reset_l),
        .dispatch_d       (dispatch_d),
        .hold_r           (hold_r),
        .hold_e           (hold_e),
        .hold_c           (hold_c),
        .kill_e           (kill_e),
        .trap_req_c       (trap_req_c),
        .trap_done        (trap_done),
        .optop_wr_e       (optop_wr_e),
        .optop_wr_c       (optop_wr_c),
        .optop_restore    (optop_restore),
        .pc_enable        (pc_enable),
        .optop_enable     (optop_enable),
        .optop_sel_e      (optop_sel_e),
        .optop_sel_c      (optop_sel_c),
        .trap_in_progress (trap_in_progress),
        .valid_r          (valid_r),
        .valid_e          (valid_e),
        .valid_c          (valid_c)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dispatch_d = 0; hold_r = 0; hold_e = 0; hold_c = 0; kill_e = 0;
        trap_req_c = 0; trap_done = 0; optop_wr_e = 0; optop_wr_c = 0; optop_restore = 0;
    endtask

    initial begin
        clear_inputs();
        reset_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valids", {29'd0, valid_r, valid_e, valid_c}, 32'd0);
        check_eq("rst_trap", {31'd0, trap_in_progress}, 32'd0);
        check_eq("rst_pc_en", {29'd0, pc_enable}, 32'd0);
        check_eq("rst_optop_en", {29'd0, optop_enable}, 32'h3);
        check_eq("rst_sel_c", {28'd0, optop_sel_c}, 32'h8);

        // Release mid-cycle: still INIT until the next edge.
        #3 reset_l = 1'b1;
        #1;
        check_eq("init_sel_c", {28'd0, optop_sel_c}, 32'h8);
        check_eq("init_sel_e", {28'd0, optop_sel_e}, 32'h8);
        check_eq("init_optop_en", {29'd0, optop_enable}, 32'h3);
        check_eq("init_pc_en", {29'd0, pc_enable}, 32'd0);

        step();
        check_eq("run_sel_c", {28'd0, optop_sel_c}, 32'h1);
        check_eq("run_sel_e", {28'd0, optop_sel_e}, 32'h1);
        check_eq("run_optop_en", {29'd0, optop_enable}, 32'h1);
        check_eq("run_pc_en", {29'd0, pc_enable}, 32'h2);

        // Fill the pipe with three dispatches.
        dispatch_d = 1;
        #1 check_eq("fill1_pc_en", {29'd0, pc_enable}, 32'h3);
        step();
        check_eq("fill1_vr", {31'd0, valid_r}, 32'd1);
        check_eq("fill2_pc_en", {29'd0, pc_enable}, 32'h3);
        step();
        check_eq("fill2_ve", {31'd0, valid_e}, 32'd1);
        check_eq("fill3_pc_en", {29'd0, pc_enable}, 32'h7);
        check_eq("fill3_optop_en", {29'd0, optop_enable}, 32'h3);
        step();
        check_eq("fill3_vc", {31'd0, valid_c}, 32'd1);

        // Bubble into R, then stall E.
        dispatch_d = 0;
        step();
        check_eq("bubble_vrec", {29'd0, valid_r, valid_e, valid_c}, 32'h3);
        hold_e = 1; dispatch_d = 1;
        #1 check_eq("hold_e_pc_en", {29'd0, pc_enable}, 32'h4);
        step();
        check_eq("hold_e_vr", {31'd0, valid_r}, 32'd0);
        check_eq("hold_e_ve", {31'd0, valid_e}, 32'd1);
        hold_e = 0; dispatch_d = 0;
        #1 check_eq("release_pc_en", {29'd0, pc_enable}, 32'h6);
        step();
        check_eq("release_vrec", {29'd0, valid_r, valid_e, valid_c}, 32'h1);

        // Trap and kill together: trap wins.
        kill_e = 1; trap_req_c = 1;
        #1 check_eq("trapreq_pc_en", {29'd0, pc_enable}, 32'h2);
        step();
        clear_inputs();
        trap_done = 1;
        #1;
        check_eq("tenter_trap", {31'd0, trap_in_progress}, 32'd1);
        check_eq("tenter_pc_en", {29'd0, pc_enable}, 32'h2);
        check_eq("tenter_optop_en", {29'd0, optop_enable}, 32'h4);
        check_eq("tenter_vr_ve", {30'd0, valid_r, valid_e}, 32'd0);
        step();
        trap_done = 0;
        #1;
        check_eq("tbuild_trap", {31'd0, trap_in_progress}, 32'd1);
        check_eq("tbuild_pc_en", {29'd0, pc_enable}, 32'd0);
        check_eq("tbuild_optop_en", {29'd0, optop_enable}, 32'd0);
        check_eq("tbuild_vrec", {29'd0, valid_r, valid_e, valid_c}, 32'h2);
        repeat (5) step();
        check_eq("tbuild5_trap", {31'd0, trap_in_progress}, 32'd1);
        optop_wr_c = 1;
        #1 check_eq("tbuild_wrc_en", {29'd0, optop_enable}, 32'h2);
        check_eq("tbuild_wrc_sel", {28'd0, optop_sel_c}, 32'h2);
        optop_wr_c = 0; trap_done = 1;
        #1 check_eq("tdone_trap_still", {31'd0, trap_in_progress}, 32'd1);
        step();
        trap_done = 0;
        #1;
        check_eq("tdone_trap_fall", {31'd0, trap_in_progress}, 32'd0);
        check_eq("tdone_pc_en", {29'd0, pc_enable}, 32'h6);

        // Restore beats write.
        hold_c = 1; optop_restore = 1; optop_wr_e = 1;
        #1;
        check_eq("restore_sel_e", {28'd0, optop_sel_e}, 32'h4);
        check_eq("restore_sel_c", {28'd0, optop_sel_c}, 32'h4);
        check_eq("restore_optop_en", {29'd0, optop_enable}, 32'h3);
        optop_restore = 0;
        #1;
        check_eq("wr_e_sel_e", {28'd0, optop_sel_e}, 32'h2);
        check_eq("wr_e_sel_c", {28'd0, optop_sel_c}, 32'h1);
        check_eq("wr_e_optop_en", {29'd0, optop_enable}, 32'h1);
        clear_inputs();

        // Dispatch under hold_r does not load R.
        hold_r = 1; dispatch_d = 1;
        #1 check_eq("hold_r_pc_en", {29'd0, pc_enable}, 32'h6);
        step();
        check_eq("hold_r_vr", {31'd0, valid_r}, 32'd0);
        clear_inputs();

        // Reset during trap build.
        trap_req_c = 1;
        step();
        trap_req_c = 0;
        step();
        check_eq("tbuild2_trap", {31'd0, trap_in_progress}, 32'd1);
        #2 reset_l = 1'b0;
        #1;
        check_eq("midrst_trap", {31'd0, trap_in_progress}, 32'd0);
        check_eq("midrst_valids", {29'd0, valid_r, valid_e, valid_c}, 32'd0);
        check_eq("midrst_sel_e", {28'd0, optop_sel_e}, 32'h8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
